// File: rtl/img2col_pkg.sv
// img2col_pkg: definitions shared by the img2col mapping blocks.
//   ADDR_W          width of PU number, PU address, row and round buses
//                   (shared with Map_Control)
//   DEFAULT_DATA_W  default pixel width
//   DEFAULT_K       default pixels per window column
//   TAG_W           width of the optional {row, round} column tag
//   resp_state_t    PU responder state: IDLE, FILL, EMIT
//   wrap_inc        modulo-row increment for the window counter
package img2col_pkg;

  localparam int ADDR_W         = 6;
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_K      = 5;
  localparam int TAG_W          = 2 * ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } resp_state_t;

  // Next window count; row-1 wraps back to zero.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] v,
                                                 input int row);
    if (int'(v) >= row - 1) return '0;
    return v + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/img2col_pu_responder_if.sv
// img2col_pu_responder_if: window-column output channel of a PU responder.
// Optional macro IMG2COL_RESP_TAG_EN adds the win_tag signal.
//
// Handshake: the master raises win_valid with win_data/win_idx (and win_tag)
// and holds all of them stable until a cycle where win_ready is also high;
// that cycle is the transfer. win_ready may be raised or dropped at any time
// and has no effect while win_valid is low.
//
//   win_valid  master->slave  column valid
//   win_ready  slave->master  downstream ready
//   win_data   master->slave  K*DATA_W column, entry i at [i*DATA_W +: DATA_W]
//   win_idx    master->slave  window count modulo ROW
//   win_tag    master->slave  {row_no, round_no} of the column's first pixel
interface img2col_pu_responder_if
  import img2col_pkg::*;
#(
  parameter int K      = DEFAULT_K,
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  logic                  win_valid;
  logic                  win_ready;
  logic [K*DATA_W-1:0]   win_data;
  logic [ADDR_W-1:0]     win_idx;
`ifdef IMG2COL_RESP_TAG_EN
  logic [TAG_W-1:0]      win_tag;
`endif

  modport master (
    output win_valid,
    output win_data,
    output win_idx,
`ifdef IMG2COL_RESP_TAG_EN
    output win_tag,
`endif
    input  win_ready
  );

  modport slave (
    input  win_valid,
    input  win_data,
    input  win_idx,
`ifdef IMG2COL_RESP_TAG_EN
    input  win_tag,
`endif
    output win_ready
  );

endinterface

// File: rtl/img2col_pu_responder_pu_col_buffer.sv
// pu_col_buffer: K x DATA_W column register file with a per-entry write mask.
//   clk, nrst  clock, synchronous active-low reset (clears data and mask)
//   wr_en      write strobe; wr_addr selects the entry, wr_data is stored
//   clr        clears the mask only (data is kept); wins over wr_en
//   full       all K mask bits set (registered mask)
//   col        packed column, entry i at [i*DATA_W +: DATA_W]
module pu_col_buffer
  import img2col_pkg::*;
#(
  parameter int K      = DEFAULT_K,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                clr,
  output logic                full,
  output logic [K*DATA_W-1:0] col
);

  logic [K-1:0]      mask;
  logic [DATA_W-1:0] mem [K];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      mask <= '0;
      for (int i = 0; i < K; i++) mem[i] <= '0;
    end else if (clr) begin
      mask <= '0;
    end else if (wr_en) begin
      // Decoded compare keeps out-of-range addresses harmless.
      for (int i = 0; i < K; i++) begin
        if (wr_addr == ADDR_W'(i)) begin
          mem[i]  <= wr_data;
          mask[i] <= 1'b1;
        end
      end
    end
  end

  assign full = &mask;

  always_comb begin
    col = '0;
    for (int i = 0; i < K; i++) col[i*DATA_W +: DATA_W] = mem[i];
  end

endmodule

// File: rtl/img2col_pu_responder.sv
// img2col_pu_responder: per-PU responder of the img2col mapping protocol.
// Collects the K pixels addressed to PU_IDX, raises t_flag for one cycle when
// the column is complete, offers the column on the win channel, and after the
// transfer hands it to the neighbour PU with a one-cycle neighbour_out_flag.
// Optional macro IMG2COL_RESP_TAG_EN adds win_tag = {row_no, round_no}
// captured at the column's first pixel write.
//
//   clk, nrst           clock, synchronous active-low reset
//   pu_no, pu_add       target PU and pixel address from Map_Control
//   row_no, round_no    current row / round (feed the optional tag only)
//   map_finish          end of mapping pass
//   pix_in, pix_valid   pixel write data / strobe
//   win                 window column channel (master side)
//   t_flag              column-complete pulse to Map_Control
//   neighbour_out_flag  column-passed pulse
//   nb_data             column handed to the neighbour PU
//   dbg_state           current FSM state
module img2col_pu_responder
  import img2col_pkg::*;
#(
  parameter int ROW    = 28,
  parameter int K      = DEFAULT_K,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int PU_IDX = 0
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [ADDR_W-1:0]        pu_no,
  input  logic [ADDR_W-1:0]        pu_add,
  input  logic [ADDR_W-1:0]        row_no,
  input  logic [ADDR_W-1:0]        round_no,
  input  logic                     map_finish,
  input  logic [DATA_W-1:0]        pix_in,
  input  logic                     pix_valid,
  img2col_pu_responder_if.master   win,
  output logic                     t_flag,
  output logic                     neighbour_out_flag,
  output logic [K*DATA_W-1:0]      nb_data,
  output resp_state_t              dbg_state
);

  resp_state_t         state, state_nxt;
  logic                wr_hit;
  logic                buf_wr, buf_clr;
  logic                col_full;
  logic [K*DATA_W-1:0] col;
  logic                fin_pend, fin_pend_nxt;
  logic [ADDR_W-1:0]   idx_q, idx_nxt;
  logic                handshake;
  logic                nb_flag_q;
  logic [K*DATA_W-1:0] nb_q;

  assign wr_hit    = pix_valid && (pu_no == ADDR_W'(PU_IDX)) && (pu_add < ADDR_W'(K));
  assign handshake = (state == EMIT) && win.win_ready;

  pu_col_buffer #(
    .K      (K),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (buf_wr),
    .wr_addr (pu_add),
    .wr_data (pix_in),
    .clr     (buf_clr),
    .full    (col_full),
    .col     (col)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      fin_pend  <= 1'b0;
      idx_q     <= '0;
      nb_flag_q <= 1'b0;
      nb_q      <= '0;
    end else begin
      state     <= state_nxt;
      fin_pend  <= fin_pend_nxt;
      idx_q     <= idx_nxt;
      nb_flag_q <= handshake;
      if (handshake) nb_q <= col;
    end
  end

  always_comb begin
    state_nxt    = state;
    fin_pend_nxt = fin_pend;
    idx_nxt      = idx_q;
    buf_wr       = 1'b0;
    buf_clr      = 1'b0;
    t_flag       = 1'b0;
    unique case (state)
      IDLE: begin
        if (map_finish) begin
          buf_clr = 1'b1;
          idx_nxt = '0;
        end else if (wr_hit) begin
          buf_wr    = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        // map_finish drops a coincident write and suppresses t_flag.
        if (map_finish) begin
          buf_clr   = 1'b1;
          idx_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          buf_wr = wr_hit;
          // Registered mask: t_flag lands the cycle after the last write.
          if (col_full) begin
            t_flag    = 1'b1;
            state_nxt = EMIT;
          end
        end
      end
      EMIT: begin
        // A finish seen while offering is remembered and applied to the
        // counter once the column has been taken.
        if (map_finish) fin_pend_nxt = 1'b1;
        if (win.win_ready) begin
          buf_clr      = 1'b1;
          fin_pend_nxt = 1'b0;
          idx_nxt      = (fin_pend || map_finish) ? '0 : wrap_inc(idx_q, ROW);
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign win.win_valid   = (state == EMIT);
  assign win.win_data    = (state == EMIT) ? col : '0;
  assign win.win_idx     = idx_q;
  assign neighbour_out_flag = nb_flag_q;
  assign nb_data         = nb_q;
  assign dbg_state       = state;

`ifdef IMG2COL_RESP_TAG_EN
  logic [TAG_W-1:0] tag_q;
  logic             tag_load;

  // The write that leaves IDLE is the first pixel of a column.
  assign tag_load = (state == IDLE) && buf_wr;

  always_ff @(posedge clk) begin
    if (!nrst)         tag_q <= '0;
    else if (tag_load) tag_q <= {row_no, round_no};
  end

  assign win.win_tag = (state == EMIT) ? tag_q : '0;
`else
  // Row and round only feed the tag.
  logic unused_tag_inputs;
  assign unused_tag_inputs = ^{row_no, round_no};
`endif

endmodule

// File: doc/img2col_pu_responder.md
Name: img2col_pu_responder

Overview:
- Per-PU responder on the PU side of the img2col mapping protocol. Map_Control drives PU number, PU address, row and round; this block answers.
- Captures the K pixels addressed to its PU index and returns the per-PU t_flag completion flag.
- Presents the completed window column downstream over a valid/ready handshake.
- After the column is accepted, passes it to the neighbour PU and pulses neighbour_out_flag.
- One instance per PU; ROW instances form the t_flag and neighbour_out_flag vectors.

Parameters:
- ROW, 28, number of PUs; sets the win_idx wrap point.
- K, 5, pixels per window column; PU addresses 0..K-1 are valid.
- DATA_W, 8, pixel width in bits.
- PU_IDX, 0, index of this PU, 0..ROW-1.

Ports:
- clk  in  1  single clock, rising edge.
- nrst  in  1  synchronous active-low reset.
- pu_no  in  6  current_PU_No from Map_Control.
- pu_add  in  6  current_PU1_add from Map_Control.
- row_no  in  6  current_row_No.
- round_no  in  6  current_round.
- map_finish  in  1  end of mapping pass.
- pix_in  in  DATA_W  pixel write data.
- pix_valid  in  1  pixel write strobe.
- win_ready  in  1  downstream ready.
- win_valid  out  1  window column valid.
- win_data  out  K*DATA_W  column; entry i is at bits [i*DATA_W +: DATA_W].
- win_idx  out  6  window count modulo ROW.
- t_flag  out  1  column-complete pulse to Map_Control.
- neighbour_out_flag  out  1  column-passed pulse.
- nb_data  out  K*DATA_W  column handed to the neighbour PU.

Behaviour:
- Reset (nrst=0 at a clk edge) applies in every state, including mid-operation:
  - state=IDLE, write mask=0, buffer=0.
  - All outputs 0, win_idx=0.
- Write hit = pix_valid && pu_no==PU_IDX && pu_add<K.
  - On a hit: buf[pu_add]<=pix_in and mask[pu_add]<=1.
  - A repeated address overwrites the data; the mask is unchanged.
  - pu_add>=K is ignored.
- States:
  - IDLE: a write hit performs the write and moves to FILL.
  - FILL: accepts write hits. When the mask becomes all ones (the registered mask, checked the cycle after the last write), t_flag=1 for exactly 1 cycle and the block moves to EMIT.
  - EMIT: win_valid=1 and win_data=buf, held stable until win_ready. Write hits in EMIT are ignored.
  - On the handshake (win_valid && win_ready):
    - Next cycle: neighbour_out_flag=1 for 1 cycle; nb_data<=buf, held until the next pass.
    - mask cleared.
    - win_idx increments; ROW-1 wraps to 0.
    - Next state is IDLE.
- Latency:
  - Last write to t_flag: 1 cycle.
  - t_flag to win_valid: 1 cycle.
  - Handshake to neighbour_out_flag: 1 cycle.
- map_finish:
  - In IDLE or FILL: next state IDLE, mask cleared, win_idx=0, no t_flag.
  - In EMIT: deferred until the handshake completes, then win_idx=0.
- Same cycle as the final write: map_finish has priority, the write is dropped and no t_flag is raised.
- t_flag and neighbour_out_flag are never high in the same cycle.

Optional Feature:
- Macro IMG2COL_RESP_TAG_EN.
- Defined:
  - Extra output win_tag, 12 bits = {row_no, round_no}, sampled at the cycle of the first write hit of a column.
  - Held with win_data; same valid/ready stability rules.
- Undefined: no win_tag port and no tag registers. All other behaviour is identical.

Decomposition:
- Package img2col_pkg:
  - State enum resp_state_t {IDLE, FILL, EMIT}.
  - Address width constant ADDR_W=6 (shared with Map_Control).
  - Default DATA_W and K.
- Sub-module pu_col_buffer: K x DATA_W register file with write mask, all-full flag and clear. The FSM and counter stay in the top.

Test Plan:
- Full column, immediate accept:
  - Stimulus: PU_IDX=3, pu_no=3, pu_add 0..4, pix 0x10..0x14 on consecutive cycles, win_ready=1.
  - Response: t_flag pulses 1 cycle; win_data={0x14,0x13,0x12,0x11,0x10}; neighbour_out_flag 1 cycle later; win_idx=1.
- Non-matching and out-of-range writes:
  - Stimulus: pu_no=4 writes, then pu_add=5 writes.
  - Response: mask stays 0, no t_flag, state stays IDLE.
- Backpressure:
  - Stimulus: win_ready=0 for 6 cycles, with writes issued during EMIT.
  - Response: win_valid and win_data stable; writes ignored; handshake on the cycle win_ready=1.
- Wrap:
  - Stimulus: 28 complete columns.
  - Response: win_idx returns to 0.
- map_finish:
  - map_finish after 3 writes → IDLE, no t_flag, win_idx=0.
  - map_finish during EMIT → handshake still completes, then win_idx=0.
- Reset and tag:
  - nrst=0 mid-FILL → all outputs 0 next edge.
  - With IMG2COL_RESP_TAG_EN, row 2 / round 7 → win_tag=0x087.
